mont_exp_ctrl: RTL and testbench
================================

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 SHALL have parameter: W, 256, operand/key width in bits.
REQ-002 SHALL have ports, one per line, as below; one clock, reset synchronous active-high.
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  i_start  in  1  one-cycle request to begin exponentiation
  i_N  in  W  modulus
  i_t  in  W  precomputed base y*2^W mod N
  i_d  in  W  exponent
  o_busy  out  1  high from the cycle after accepted start until o_finish
  o_finish  out  1  one-cycle pulse, o_result valid
  o_result  out  W  y^d mod N, held until next accepted start
  o_mp_start  out  1  one-cycle start pulse to Montgomery product unit
  o_mp_N  out  W  modulus to product unit
  o_mp_a  out  W  multiplier operand a
  o_mp_b  out  W  multiplicand operand b
  i_mp_m  in  W  product unit result a*b*2^-W mod N
  i_mp_finish  in  1  product unit one-cycle done pulse, i_mp_m valid in that cycle

Function
REQ-003 SHALL be the sole sequencer of one shared Montgomery product unit; never more than one product outstanding.
REQ-004 SHALL implement states IDLE, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, DONE.
REQ-005 IDLE: i_start=1 SHALL latch N, t, d into internal registers, set m=1, idx=0; next state MUL_REQ if d[0]=1 else SQR_REQ.
REQ-006 i_start while not IDLE SHALL be ignored; latched operands SHALL not change.
REQ-007 MUL_REQ: o_mp_start=1 for exactly that cycle, o_mp_a=m, o_mp_b=t; next MUL_WAIT.
REQ-008 MUL_WAIT: on i_mp_finish=1, m<=i_mp_m; next SQR_REQ; otherwise stay.
REQ-009 SQR_REQ: o_mp_start=1 for exactly that cycle, o_mp_a=t, o_mp_b=t; next SQR_WAIT.
REQ-010 SQR_WAIT: on i_mp_finish=1, t<=i_mp_m; if idx=W-1 next DONE, else idx<=idx+1 and next MUL_REQ if d[idx+1]=1 else SQR_REQ.
REQ-011 o_mp_N, o_mp_a, o_mp_b SHALL stay constant from REQ state through matching WAIT state including the finish cycle.
REQ-012 o_mp_start SHALL be 0 in all states other than MUL_REQ, SQR_REQ.
REQ-013 No assumption on product latency; WAIT states SHALL hold indefinitely until i_mp_finish.
REQ-014 i_mp_finish outside a WAIT state SHALL be ignored (no register change).
REQ-015 DONE: o_result<=m, o_finish=1 for one cycle, o_busy=0; next IDLE; accepts i_start from IDLE on the following cycle.
REQ-016 Product count per run SHALL be exactly W + popcount(d); final squaring is performed and discarded.
REQ-017 d=0 SHALL yield o_result=1 after W squarings.
REQ-018 idx SHALL be ceil(log2(W)) bits, never wraps past W-1.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, o_busy=0, o_finish=0, o_mp_start=0, o_result=0, m, t, N, d, idx=0, regardless of state.
REQ-020 Reset mid-run SHALL abort with no o_finish; a subsequent stray i_mp_finish SHALL be ignored per REQ-014.
REQ-021 rst and i_start in the same cycle: rst SHALL win.

Verification
REQ-022 N=13, t=6 (y=2), d=5 -> o_result=6, o_finish one pulse, 258 o_mp_start pulses.
REQ-023 N=13, t=6, d=0 -> o_result=1, 256 o_mp_start pulses, all with a=b.
REQ-024 Random 256-bit odd N, y<N, d with behavioral product model of random latency 1-300 cycles -> o_result equals y^d mod N; operands stable per REQ-011.
REQ-025 i_start pulsed during MUL_WAIT with different operands -> ignored, result matches original request.
REQ-026 rst asserted in SQR_WAIT, then i_mp_finish pulsed -> state IDLE, no o_finish, all outputs 0; next run of REQ-022 correct.
REQ-027 i_mp_finish pulsed in IDLE and on the cycle after o_finish -> no register or output change.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// -----------------------------------------------------------------------------
// mont_exp_ctrl
//   Right-to-left binary modular exponentiation sequencer. Drives a single
//   external Montgomery product unit (one product in flight at a time) to
//   compute y^d mod N.
//
//   The base arrives already in Montgomery form (t = y*2^W mod N), while the
//   accumulator m starts at the plain integer 1. Each multiply
//   mont(m, t) = m*t*2^-W strips one factor of 2^W, so m stays in ordinary form
//   throughout. The final result therefore needs no conversion out of the
//   Montgomery domain.
//
//   For every exponent bit, LSB first: if d[idx] is set, m = mont(m, t). Then
//   t = mont(t, t) unconditionally. This gives W + popcount(d) products per run.
//   The last squaring is computed and then thrown away.
//
// Parameters
//   W            operand / exponent width in bits
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_start      one-cycle request; accepted only in IDLE
//   i_N          modulus
//   i_t          base in Montgomery form
//   i_d          exponent
//   o_busy       high while a run is in progress (REQ/WAIT states)
//   o_finish     one-cycle pulse; o_result is valid in that cycle
//   o_result     y^d mod N; held until the next run completes
//   o_mp_start   one-cycle start pulse to the product unit
//   o_mp_N       modulus to the product unit
//   o_mp_a       operand a to the product unit
//   o_mp_b       operand b to the product unit
//   i_mp_m       product unit result a*b*2^-W mod N
//   i_mp_finish  product unit done pulse; i_mp_m is valid in that cycle
// -----------------------------------------------------------------------------
module mont_exp_ctrl #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_N,
    input  logic [W-1:0] i_t,
    input  logic [W-1:0] i_d,
    output logic         o_busy,
    output logic         o_finish,
    output logic [W-1:0] o_result,
    output logic         o_mp_start,
    output logic [W-1:0] o_mp_N,
    output logic [W-1:0] o_mp_a,
    output logic [W-1:0] o_mp_b,
    input  logic [W-1:0] i_mp_m,
    input  logic         i_mp_finish
);

    localparam int            IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
    localparam logic [W-1:0]  ONE      = W'(1);

    typedef enum logic [2:0] {
        IDLE,
        MUL_REQ,
        MUL_WAIT,
        SQR_REQ,
        SQR_WAIT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  n_q, n_d;
    logic [W-1:0]  t_q, t_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  m_q, m_d;
    logic [W-1:0]  result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] idx_inc;

    assign idx_inc = idx_q + 1'b1;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        t_d        = t_q;
        d_d        = d_q;
        m_d        = m_q;
        result_d   = result_q;
        idx_d      = idx_q;
        o_mp_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    n_d     = i_N;
                    t_d     = i_t;
                    d_d     = i_d;
                    m_d     = ONE;
                    idx_d   = '0;
                    state_d = i_d[0] ? MUL_REQ : SQR_REQ;
                end
            end
            MUL_REQ: begin
                o_mp_start = 1'b1;
                state_d    = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (i_mp_finish) begin
                    m_d     = i_mp_m;
                    state_d = SQR_REQ;
                end
            end
            SQR_REQ: begin
                o_mp_start = 1'b1;
                state_d    = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (i_mp_finish) begin
                    t_d = i_mp_m;
                    if (idx_q == IDX_LAST) begin
                        // Capture m on the way into DONE. That way o_result is
                        // already valid in the same cycle as the o_finish pulse.
                        result_d = m_q;
                        state_d  = DONE;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = d_q[idx_inc] ? MUL_REQ : SQR_REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            t_q      <= '0;
            d_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            t_q      <= t_d;
            d_q      <= d_d;
            m_q      <= m_d;
            result_q <= result_d;
            idx_q    <= idx_d;
        end
    end

    // Operand muxes depend only on registered state. They therefore hold
    // steady from each REQ cycle through the finish cycle of its WAIT state.
    assign o_busy   = (state_q == MUL_REQ) || (state_q == MUL_WAIT) ||
                      (state_q == SQR_REQ) || (state_q == SQR_WAIT);
    assign o_finish = (state_q == DONE);
    assign o_result = result_q;
    assign o_mp_N   = n_q;
    assign o_mp_a   = ((state_q == MUL_REQ) || (state_q == MUL_WAIT)) ? m_q : t_q;
    assign o_mp_b   = t_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mont_exp_ctrl
//   Bench for mont_exp_ctrl. A behavioural Montgomery product unit answers
//   each o_mp_start after a random latency. Results are compared against a
//   plain square-and-multiply modular exponentiation reference.
// -----------------------------------------------------------------------------
module tb_mont_exp_ctrl;

    localparam int W = 256;
    typedef logic [W-1:0]   word_t;
    typedef logic [2*W-1:0] dword_t;

    logic  clk = 1'b0;
    logic  rst;
    logic  i_start;
    word_t i_N, i_t, i_d;
    logic  o_busy, o_finish, o_mp_start;
    word_t o_result, o_mp_N, o_mp_a, o_mp_b;
    word_t i_mp_m;
    logic  i_mp_finish;

    // Product model response and bench-injected stray finish pulses.
    logic  model_fin, stray_fin;
    word_t model_m, stray_m;
    assign i_mp_finish = model_fin | stray_fin;
    assign i_mp_m      = stray_fin ? stray_m : model_m;

    always #5 clk = ~clk;

    mont_exp_ctrl #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_N        (i_N),
        .i_t        (i_t),
        .i_d        (i_d),
        .o_busy     (o_busy),
        .o_finish   (o_finish),
        .o_result   (o_result),
        .o_mp_start (o_mp_start),
        .o_mp_N     (o_mp_N),
        .o_mp_a     (o_mp_a),
        .o_mp_b     (o_mp_b),
        .i_mp_m     (i_mp_m),
        .i_mp_finish(i_mp_finish)
    );

    int checks = 0;
    int errors = 0;

    // Product model controls and statistics.
    int  lat_lo = 1, lat_hi = 4;
    bit  lat_long = 1'b0;
    bit  mp_abort = 1'b0;
    int  start_cnt = 0, neq_cnt = 0, fin_cnt = 0;

    task automatic check_word(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Montgomery product: reduce a*b, then divide by 2 modulo odd n, W times.
    function automatic word_t mont(input word_t a, input word_t b, input word_t n);
        dword_t p;
        p = (dword_t'(a) * dword_t'(b)) % dword_t'(n);
        for (int i = 0; i < W; i++)
            p = p[0] ? ((p + dword_t'(n)) >> 1) : (p >> 1);
        return p[W-1:0];
    endfunction

    // Plain modular exponentiation reference.
    function automatic word_t modexp(input word_t y, input word_t e, input word_t n);
        dword_t r, b;
        r = '0;
        r[0] = 1'b1;
        b = dword_t'(y) % dword_t'(n);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % dword_t'(n);
            b = (b * b) % dword_t'(n);
        end
        return r[W-1:0];
    endfunction

    function automatic word_t to_mont(input word_t y, input word_t n);
        dword_t yy;
        yy = dword_t'(y) << W;
        return word_t'(yy % dword_t'(n));
    endfunction

    function automatic word_t rand_word();
        word_t w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic int budget_for(input word_t d, input int lat);
        return (W + $countones(d) + 2) * (lat + 3) + 50;
    endfunction

    // Behavioural product unit. Runs on the falling edge; the main sequence
    // acts 1 time unit later, so the two never race.
    initial begin
        bit    pend;
        int    cnt;
        word_t cap_a, cap_b, cap_n;
        pend      = 1'b0;
        cnt       = 0;
        model_fin = 1'b0;
        model_m   = '0;
        forever begin
            @(negedge clk);
            model_fin = 1'b0;
            if (o_finish) fin_cnt++;
            if (mp_abort) begin
                pend = 1'b0;
            end else if (pend) begin
                check_bit("mp_single_outstanding", o_mp_start, 1'b0);
                check_bit("mp_operands_stable",
                          (o_mp_a === cap_a) && (o_mp_b === cap_b) && (o_mp_N === cap_n), 1'b1);
                cnt--;
                if (cnt == 0) begin
                    model_m   = mont(cap_a, cap_b, cap_n);
                    model_fin = 1'b1;
                    pend      = 1'b0;
                end
            end else if (o_mp_start) begin
                start_cnt++;
                if (o_mp_a !== o_mp_b) neq_cnt++;
                cap_a = o_mp_a;
                cap_b = o_mp_b;
                cap_n = o_mp_N;
                if (lat_long && ($urandom_range(7, 0) == 0)) cnt = $urandom_range(300, 1);
                else cnt = $urandom_range(lat_hi, lat_lo);
                pend = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats();
        start_cnt = 0;
        neq_cnt   = 0;
        fin_cnt   = 0;
    endtask

    task automatic launch(input word_t n, input word_t t, input word_t d);
        i_N     = n;
        i_t     = t;
        i_d     = d;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic finish_check(input string tag, input word_t exp, input int starts_exp,
                                input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (o_finish) ok = 1'b1;
            else step();
        end
        check_bit({tag, "_finish_seen"}, ok, 1'b1);
        check_word({tag, "_result"}, o_result, exp);
        check_bit({tag, "_busy_at_done"}, o_busy, 1'b0);
        check_int({tag, "_mp_starts"}, start_cnt, starts_exp);
        step();
        check_bit({tag, "_finish_one_pulse"}, o_finish, 1'b0);
        check_word({tag, "_result_held"}, o_result, exp);
        check_int({tag, "_finish_count"}, fin_cnt, 1);
    endtask

    task automatic run_check(input string tag, input word_t n, input word_t t, input word_t d,
                             input word_t exp, input bit long_lat);
        lat_long = long_lat;
        clear_stats();
        launch(n, t, d);
        check_bit({tag, "_busy_after_start"}, o_busy, 1'b1);
        finish_check(tag, exp, W + $countones(d), budget_for(d, long_lat ? 300 : lat_hi));
        lat_long = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_busy"}, o_busy, 1'b0);
        check_bit({tag, "_finish"}, o_finish, 1'b0);
        check_bit({tag, "_mp_start"}, o_mp_start, 1'b0);
        check_word({tag, "_result"}, o_result, '0);
        check_word({tag, "_mp_N"}, o_mp_N, '0);
        check_word({tag, "_mp_a"}, o_mp_a, '0);
        check_word({tag, "_mp_b"}, o_mp_b, '0);
    endtask

    initial begin
        word_t n, y, t, d, snap_a, snap_b, snap_n;
        rst       = 1'b1;
        i_start   = 1'b0;
        i_N       = '0;
        i_t       = '0;
        i_d       = '0;
        stray_fin = 1'b0;
        stray_m   = '0;

        // Reset state.
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Reset and start in the same cycle: reset wins.
        clear_stats();
        rst     = 1'b1;
        i_N     = word_t'(13);
        i_t     = word_t'(6);
        i_d     = word_t'(5);
        i_start = 1'b1;
        step();
        rst     = 1'b0;
        i_start = 1'b0;
        check_bit("rst_wins_busy", o_busy, 1'b0);
        repeat (4) step();
        check_int("rst_wins_no_products", start_cnt, 0);

        // Directed 2^5 mod 13 = 6.
        t = to_mont(word_t'(2), word_t'(13));
        check_word("to_mont_base", t, word_t'(6));
        run_check("d5", word_t'(13), t, word_t'(5), modexp(word_t'(2), word_t'(5), word_t'(13)), 1'b0);

        // Stray product-finish pulses while idle must change nothing.
        snap_a = o_mp_a;
        snap_b = o_mp_b;
        snap_n = o_mp_N;
        for (int k = 0; k < 2; k++) begin
            stray_fin = 1'b1;
            stray_m   = rand_word();
            step();
            stray_fin = 1'b0;
            step();
            check_word("idle_stray_result", o_result, word_t'(6));
            check_bit("idle_stray_busy", o_busy, 1'b0);
            check_bit("idle_stray_finish", o_finish, 1'b0);
            check_bit("idle_stray_mp_start", o_mp_start, 1'b0);
            check_word("idle_stray_mp_a", o_mp_a, snap_a);
            check_word("idle_stray_mp_b", o_mp_b, snap_b);
            check_word("idle_stray_mp_N", o_mp_N, snap_n);
            repeat (3) step();
        end

        // Zero exponent: only squarings, result 1.
        run_check("d0", word_t'(13), word_t'(6), '0, word_t'(1), 1'b0);
        check_int("d0_all_squares", neq_cnt, 0);

        // Start request during MUL_WAIT with other operands is ignored.
        lat_lo = 10;
        lat_hi = 10;
        clear_stats();
        launch(word_t'(13), word_t'(6), word_t'(5));
        repeat (2) step();
        i_N     = word_t'(7);
        i_t     = word_t'(3);
        i_d     = word_t'(2);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_word("busy_start_N_kept", o_mp_N, word_t'(13));
        finish_check("busy_start", word_t'(6), W + 2, budget_for(word_t'(5), 10));
        lat_lo = 1;
        lat_hi = 4;

        // Reset inside SQR_WAIT, then a stray finish.
        lat_lo = 50;
        lat_hi = 50;
        clear_stats();
        launch(word_t'(13), word_t'(6), '0);
        for (int c = 0; c < 2000 && start_cnt < 5; c++) step();
        check_int("abort_reached_5_products", start_cnt, 5);
        repeat (3) step();
        rst      = 1'b1;
        mp_abort = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("abort");
        stray_fin = 1'b1;
        stray_m   = rand_word();
        step();
        stray_fin = 1'b0;
        repeat (2) step();
        check_all_zero("abort_stray");
        check_int("abort_no_finish", fin_cnt, 0);
        mp_abort = 1'b0;
        lat_lo   = 1;
        lat_hi   = 4;
        run_check("after_abort", word_t'(13), word_t'(6), word_t'(5), word_t'(6), 1'b0);

        // Random 256-bit operands; the first run uses latencies up to 300.
        for (int r = 0; r < 3; r++) begin
            n = rand_word();
            n[0] = 1'b1;
            n[W-1] = 1'b1;
            y = rand_word() % n;
            d = rand_word();
            t = to_mont(y, n);
            run_check($sformatf("rand%0d", r), n, t, d, modexp(y, d, n), (r == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
